// File: rtl/uart_tx_buffer.sv
// Purpose: byte FIFO feeding an 8N1 UART serializer on the MEM-stage store path.
// Latency: a write into an empty, idle buffer puts the start bit on uart_tx two edges later.
// Backpressure: none; a write while full is dropped and latches the sticky overflow flag.
//
// Ports:
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    byte write strobe and data from the store path
//   full, empty       FIFO holds DEPTH / zero entries
//   count             FIFO occupancy (DEPTH_LOG2+1 bits)
//   overflow          sticky dropped-write flag, cleared only by RST
//   busy              serializer is mid-frame
//   uart_tx           registered serial line, idle high
module uart_tx_buffer #(
  parameter int BAUD_DIV   = 868,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  uart_tx
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [15:0]         BAUD_MAX = 16'(BAUD_DIV - 1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [15:0]             baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [7:0]              sh_q, sh_d;
  logic                    tx_q, tx_d;
  logic [7:0]              mem_q [DEPTH];

  logic                    wr_acc;
  logic                    pop;
  logic                    baud_end;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);
  assign uart_tx  = tx_q;

  // Both decisions use pre-edge occupancy: a byte written into an empty
  // FIFO is not popped until the following cycle, and a write while full
  // is dropped even if the serializer pops in the same cycle.
  assign wr_acc   = wr_en && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign baud_end = (baud_q == BAUD_MAX);

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Serializer next state
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (pop) begin
          sh_d    = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level follows the registered state, so the pin lags the state by
  // one cycle but never glitches; every bit still lasts BAUD_DIV cycles.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_q[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      baud_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RST) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Purpose: directed bench for uart_tx_buffer (BAUD_DIV=4, DEPTH_LOG2=2).
// Latency: checks the two-edge write-to-start-bit delay and 41-cycle frame spacing.
// Backpressure: checks full/overflow behaviour and dropped writes.
module tb_uart_tx_buffer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       busy;
  logic       uart_tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];
  logic       rx_stop [$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_tx_buffer #(.BAUD_DIV(4), .DEPTH_LOG2(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  // Line receiver: samples mid-bit on falling clock edges, 4 cycles per bit.
  initial begin
    logic [7:0] b;
    int         t0;
    b  = '0;
    t0 = 0;
    forever begin
      @(negedge CLK);
      if (uart_tx === 1'b0 && RST === 1'b0) begin
        t0 = cyc;
        repeat (5) @(negedge CLK);
        b[0] = uart_tx;
        for (int i = 1; i < 8; i++) begin
          repeat (4) @(negedge CLK);
          b[i] = uart_tx;
        end
        repeat (4) @(negedge CLK);
        rx_q.push_back(b);
        rx_t.push_back(t0);
        rx_stop.push_back(uart_tx);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic flush_rx;
    rx_q.delete();
    rx_t.delete();
    rx_stop.delete();
  endtask

  task automatic test_reset;
    RST = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    repeat (3) tick;
    total++;
    if ({uart_tx, empty, busy, full, overflow, count} !== 8'b1_1_0_0_0_000) begin
      bad++;
      $display("FAIL reset_in_rst: got %b want 11000000",
               {uart_tx, empty, busy, full, overflow, count});
    end
    RST = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      total++;
      if ({uart_tx, empty, busy, full, overflow, count} !== 8'b1_1_0_0_0_000) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: got %b want 11000000", i,
                 {uart_tx, empty, busy, full, overflow, count});
      end
    end
  endtask

  task automatic test_single_frame;
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    flush_rx;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick;                                   // edge t
    wr_en = 1'b0;
    total++;
    if (count !== 3'd1 || empty !== 1'b0) begin
      bad++;
      $display("FAIL single_after_write: count=%0d empty=%b want 1 0", count, empty);
    end
    tick;                                   // edge t+1: pop
    total++;
    if (busy !== 1'b1 || uart_tx !== 1'b1 || count !== 3'd0) begin
      bad++;
      $display("FAIL single_pop: busy=%b tx=%b count=%0d want 1 1 0", busy, uart_tx, count);
    end
    for (int k = 0; k < 40; k++) begin      // edges t+2 .. t+41
      tick;
      total++;
      if (uart_tx !== fr[k / 4]) begin
        bad++;
        $display("FAIL single_bit cycle %0d: tx=%b want %b", k, uart_tx, fr[k / 4]);
      end
    end
    total++;
    if (busy !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL single_end: busy=%b empty=%b want 0 1", busy, empty);
    end
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      bad++;
      $display("FAIL single_decode: n=%0d byte=%h want 1 a5", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  exp_b [3];
    logic [2:0]  peak;
    int          n;
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
    peak = '0;
    flush_rx;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = exp_b[i];
      tick;
      if (count > peak) peak = count;
    end
    wr_en = 1'b0;
    n = 0;
    while (rx_q.size() < 3 && n < 300) begin
      tick;
      if (count > peak) peak = count;
      n++;
    end
    total++;
    if (rx_q.size() < 3) begin
      bad++;
      $display("FAIL b2b_timeout: frames=%0d want 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rx_q[i] !== exp_b[i] || rx_stop[i] !== 1'b1) begin
          bad++;
          $display("FAIL b2b_byte %0d: got %h stop=%b want %h stop=1", i, rx_q[i], rx_stop[i], exp_b[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (rx_t[i] - rx_t[i-1] != 41) begin
          bad++;
          $display("FAIL b2b_spacing %0d: got %0d want 41", i, rx_t[i] - rx_t[i-1]);
        end
      end
    end
    total++;
    if (peak !== 3'd2) begin
      bad++;
      $display("FAIL b2b_peak: got %0d want 2", peak);
    end
    n = 0;
    while ((busy !== 1'b0 || empty !== 1'b1) && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic test_overflow;
    int n;
    flush_rx;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      tick;
      if (i == 4) begin
        total++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
          bad++;
          $display("FAIL ovf_fill: full=%b count=%0d ovf=%b want 1 4 0", full, count, overflow);
        end
      end
    end
    wr_en = 1'b0;
    total++;
    if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop: ovf=%b count=%0d full=%b want 1 4 1", overflow, count, full);
    end
    n = 0;
    while (rx_q.size() < 5 && n < 300) begin
      tick;
      n++;
    end
    repeat (100) tick;
    total++;
    if (rx_q.size() != 5) begin
      bad++;
      $display("FAIL ovf_frames: got %0d want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (rx_q[i] !== 8'h10 + 8'(i)) begin
          bad++;
          $display("FAIL ovf_byte %0d: got %h want %h", i, rx_q[i], 8'h10 + 8'(i));
        end
      end
    end
    total++;
    if (overflow !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ovf_sticky: ovf=%b empty=%b busy=%b want 1 1 0", overflow, empty, busy);
    end
  endtask

  task automatic test_reset_midframe;
    int lows;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL rst_clears_ovf: ovf=%b want 0", overflow);
    end
    flush_rx;
    wr_en = 1'b1; wr_data = 8'hF7; tick;    // edge t
    wr_data = 8'h55; tick;                  // edge t+1
    wr_data = 8'h66; tick;                  // edge t+2
    wr_en = 1'b0;
    repeat (17) tick;                       // edge t+19: data bit 3 on the line
    total++;
    if (count !== 3'd2 || busy !== 1'b1 || uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre: count=%0d busy=%b tx=%b want 2 1 0", count, busy, uart_tx);
    end
    RST = 1'b1;
    tick;
    RST = 1'b0;
    total++;
    if ({uart_tx, count, overflow, busy, empty, full} !== 8'b1_000_0_0_1_0) begin
      bad++;
      $display("FAIL rst_mid: got %b want 10000010",
               {uart_tx, count, overflow, busy, empty, full});
    end
    repeat (50) tick;
    flush_rx;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick;
      if (uart_tx !== 1'b1) lows++;
    end
    total++;
    if (lows != 0 || rx_q.size() != 0 || empty !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_quiet: lows=%0d frames=%0d empty=%b busy=%b want 0 0 1 0",
               lows, rx_q.size(), empty, busy);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] base;
    int         n;
    for (int r = 0; r < 3; r++) begin
      base = 8'h20 + 8'(r * 16);
      flush_rx;
      for (int i = 0; i < 5; i++) begin
        wr_en = 1'b1; wr_data = base + 8'(i);
        tick;
      end
      wr_en = 1'b0;
      total++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL wrap_full round %0d: full=%b ovf=%b want 1 0", r, full, overflow);
      end
      n = 0;
      while (rx_q.size() < 5 && n < 300) begin
        tick;
        n++;
      end
      n = 0;
      while (busy !== 1'b0 && n < 20) begin
        tick;
        n++;
      end
      total++;
      if (rx_q.size() != 5) begin
        bad++;
        $display("FAIL wrap_frames round %0d: got %0d want 5", r, rx_q.size());
      end else begin
        for (int i = 0; i < 5; i++) begin
          total++;
          if (rx_q[i] !== base + 8'(i)) begin
            bad++;
            $display("FAIL wrap_byte round %0d idx %0d: got %h want %h", r, i, rx_q[i], base + 8'(i));
          end
        end
      end
      total++;
      if (count !== 3'd0 || empty !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL wrap_drain round %0d: count=%0d empty=%b busy=%b want 0 1 0",
                 r, count, empty, busy);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_reset_midframe;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte-wide transmit buffer plus 8N1 serializer on the MEM-stage UART store path.
- Consumes the core's UART write strobe and byte, the same signals generated when a store in MEM hits `UART_ADDR`.
- Queues bytes in a FIFO so back-to-back stores are not lost while a frame is on the wire.
- Drives the board `uart_tx` pin directly. Status outputs allow a later memory-mapped status read or pipeline stall.

Parameters:
- BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 entries.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- wr_en  in  1  write strobe from MEM stage (store to `UART_ADDR`).
- wr_data  in  8  byte to transmit (`store_dataM[7:0]`).
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  DEPTH_LOG2+1  current FIFO occupancy.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- busy  out  1  serializer not in IDLE.
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RST).
- Reset values:
  - count=0, full=0, empty=1, overflow=0, busy=0, uart_tx=1.
  - FSM=IDLE; read pointer, write pointer, bit counter and baud counter = 0.
  - Reset asserted mid-frame aborts the frame; uart_tx is 1 on the cycle after the RST edge.
- FIFO:
  - Write is accepted iff wr_en=1 and full=0, judged on pre-edge state.
  - A write while full is dropped, sets overflow=1, and leaves FIFO contents and pointers unchanged.
  - overflow clears only on RST.
  - Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH.
  - count = written minus popped, updated every edge. A simultaneous accepted write and pop leaves count unchanged.
  - full and empty are derived from the registered count.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE, uart_tx=1:
    - If empty=0: pop the head entry into shift register sh[7:0]; next state START; baud counter=0.
    - Otherwise stay in IDLE.
  - START, uart_tx=0 for BAUD_DIV cycles; then DATA with bit index=0.
  - DATA, uart_tx=sh[bit index], LSB first, each bit held BAUD_DIV cycles.
    - After bit 7 completes: STOP.
  - STOP, uart_tx=1 for BAUD_DIV cycles; then IDLE.
  - uart_tx is registered (glitch-free) and equals the level stated for the current state.
- Baud counter: counts 0..BAUD_DIV-1 and the state/bit advances on the cycle the counter equals BAUD_DIV-1. Counter width is 16 bits.
- busy = (state != IDLE).
- Timing:
  - Latency, write to start bit: wr_en at edge t into an empty FIFO with FSM in IDLE → count=1 after t; pop at edge t+1; uart_tx=0 after edge t+2.
  - Frame length is 10×BAUD_DIV cycles.
  - Queued frames are separated by exactly 1 idle-high cycle (the IDLE pop cycle). Successive start bits are 10×BAUD_DIV+1 cycles apart.
- Simultaneous events:
  - Write to an empty FIFO in the same cycle the FSM is in IDLE is not popped that cycle; the pop occurs next cycle.
  - Write while full in the same cycle as an IDLE pop is still dropped, because full is judged pre-edge.
  - Pop never occurs when empty=1.

Test Plan:
- RST held 3 cycles, then released with no writes → uart_tx=1, empty=1, count=0, busy=0 for 100 cycles.
- BAUD_DIV=4; single write 0xA5 → uart_tx low 2 cycles after wr_en, then bits 1,0,1,0,0,1,0,1 (LSB first) at 4 cycles each, then stop high. Total 40 cycles of frame, then busy=0, empty=1.
- BAUD_DIV=4; write 0x01,0x02,0x03 on consecutive cycles → count peaks at 2 (first already popped). Three frames decode in order 0x01,0x02,0x03. Start bits are 41 cycles apart.
- BAUD_DIV=4, DEPTH_LOG2=2; write 6 bytes back-to-back → first popped; next 4 fill the FIFO (full=1); 6th dropped with overflow=1 sticky. Exactly 5 frames are transmitted.
- BAUD_DIV=4; assert RST during DATA bit 3 of a frame with 2 bytes still queued → next cycle uart_tx=1, count=0, overflow=0, busy=0. No further frames are sent.
- DEPTH_LOG2=2; fill, drain fully, then refill twice → data order preserved across pointer wrap. count returns to 0 and empty=1 after each drain.
